// File: rtl/mult_div_sequencer.sv
// Multicycle unsigned MULTU/DIVU sequencer driving a shared external 32-bit adder-subtractor.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle, 32 steps.
module mult_div_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_sub,
    input  logic [31:0] add_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  count;
    logic [31:0] m;
    logic        op_q;

    logic [31:0] rp;
    logic        t;
    logic        carry;
    logic [31:0] hi_next;
    logic [31:0] lo_next;

    // Partial remainder for the divide step: {HI,LO} shifted left by one, bit 32 kept in t.
    always_comb begin
        rp = {hi[30:0], lo[31]};
        t  = hi[31];
    end

    always_comb begin
        add_a   = 32'd0;
        add_b   = 32'd0;
        add_sub = 1'b0;
        if (state == RUN) begin
            add_b = m;
            if (op_q) begin
                add_a   = rp;
                add_sub = 1'b1;
            end else begin
                add_a   = hi;
            end
        end
    end

    // The shared adder has no carry-out; recover it from the operand and result MSBs.
    always_comb begin
        if (add_sub)
            carry = (add_a[31] & ~add_b[31]) | (~(add_a[31] ^ add_b[31]) & ~add_result[31]);
        else
            carry = (add_a[31] & add_b[31]) | ((add_a[31] ^ add_b[31]) & ~add_result[31]);
    end

    always_comb begin
        hi_next = hi;
        lo_next = lo;
        if (op_q) begin
            if (t | carry) begin
                hi_next = add_result;
                lo_next = {lo[30:0], 1'b1};
            end else begin
                hi_next = rp;
                lo_next = {lo[30:0], 1'b0};
            end
        end else begin
            if (lo[0]) begin
                hi_next = {carry, add_result[31:1]};
                lo_next = {add_result[0], lo[31:1]};
            end else begin
                hi_next = {1'b0, hi[31:1]};
                lo_next = {hi[0], lo[31:1]};
            end
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (count == 6'd31)
                    state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= 6'd0;
            m     <= 32'd0;
            op_q  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= rt_val;
                        op_q  <= op;
                        count <= 6'd0;
                        hi    <= 32'd0;
                        lo    <= rs_val;
                    end
                end
                RUN: begin
                    hi    <= hi_next;
                    lo    <= lo_next;
                    count <= count + 6'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
